zigbee_apb_master: RTL
======================

# zigbee_apb_master

APB initiator that drives the Tx and Rx byte FIFOs of the Zigbee platform from a simple host command stream. It converts one accepted command into one APB transfer (write of a payload byte into the Tx FIFO, or read of a demodulated byte from the Rx FIFO) and returns one response carrying read data and error status. It also guards against a hung responder with a PREADY timeout and keeps a saturating error count.

## Interface
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before forced termination; legal range 1..255
- clk_i  in  1  system clock
- reset_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_target_i  in  1  0 = Tx FIFO, 1 = Rx FIFO
- cmd_write_i  in  1  1 = APB write, 0 = APB read
- cmd_wdata_i  in  8  write byte
- psel_tx_o  out  1  APB select, Tx FIFO
- psel_rx_o  out  1  APB select, Rx FIFO
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  8  APB write data
- prdata_i  in  8  APB read data, Rx FIFO
- pready_i  in  1  APB ready; tie to 1 for zero-wait responders
- pslverr_i  in  1  APB slave error, already muxed from the selected FIFO
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  8  captured prdata; 0 for writes and timeouts
- rsp_err_o  out  1  pslverr or timeout
- rsp_timeout_o  out  1  transfer ended by timeout
- err_cnt_o  out  8  saturating count of responses with rsp_err_o = 1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_o = 1. On valid & ready, register target, write and wdata, then go to SETUP. cmd_ready_o = 0 in every other state.
- SETUP: the selected psel is 1, penable_o = 0, and pwrite_o/pwdata_o are driven from the registered command. Always go to ACCESS next.
- ACCESS: psel and penable_o are 1. pwrite_o, pwdata_o and psel stay stable. A timeout counter runs from 0.
  - On pready_i = 1: capture prdata_i (reads only; 0 for writes) and pslverr_i, then go to RESP.
  - If the counter is at TIMEOUT_CYCLES-1 and pready_i = 0: rsp_err = 1, rsp_timeout = 1, rdata = 0, then go to RESP.
  - If pready_i and the timeout hit occur in the same cycle, pready wins and it is not a timeout.
- RESP: all psel and penable_o are 0. rsp_valid_o = 1 with stable payload until rsp_ready_i, then go to IDLE.
- Only one psel is ever active. pwdata_o = 0 outside SETUP/ACCESS, and 0 for reads.
- The master does not block illegal combinations (write to Rx FIFO, read from Tx FIFO). They are issued on the bus and any pslverr_i is returned.
- err_cnt_o increments on the RESP handshake when rsp_err_o = 1 and saturates at 255.
- Reset: all outputs are 0 except cmd_ready_o = 1, and the FSM returns to IDLE on the next edge. A transfer in flight or an unconsumed response is discarded, and err_cnt_o clears.

## Timing
- Zero-wait transfer: accept at cycle N, SETUP at N+1, ACCESS at N+2 (pready = 1), rsp_valid_o at N+3.
- With W wait cycles, rsp_valid_o rises at N+3+W.
- Timeout: the ACCESS phase lasts exactly TIMEOUT_CYCLES cycles, and rsp_valid_o rises at N+2+TIMEOUT_CYCLES.
- Back-to-back commands: if rsp_ready_i = 1 in the first RESP cycle, IDLE follows and the next command is accepted 4 cycles after the previous one (zero-wait throughput is 1 transfer per 4 cycles).
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package zigbee_apb_pkg holds:
  - the state enum apb_state_t {IDLE, SETUP, ACCESS, RESP};
  - the target constants TGT_FIFO_TX = 1'b0 and TGT_FIFO_RX = 1'b1;
  - the APB data width constant APB_DW = 8.
- Single module with no sub-module. The timeout counter and error counter are inline, each $clog2-sized (8 bits for err_cnt).

## Test plan
- Write 8'hA5 to Tx FIFO with pready tied to 1 -> psel_tx 1 for 2 cycles, penable 1 in the second, pwdata = A5; rsp_valid at N+3 with err 0, rdata 00.
- Read from Rx FIFO with prdata = 8'h3C and 2 wait cycles -> psel_rx held for 4 cycles; rsp_rdata = 3C at N+5; pwrite 0 throughout.
- pready stuck at 0 with TIMEOUT_CYCLES = 4 -> ACCESS lasts 4 cycles; rsp_err = 1, rsp_timeout = 1, rdata = 00; err_cnt 0 -> 1.
- pready rises in the last timeout cycle with pslverr = 1 -> rsp_err = 1, rsp_timeout = 0.
- rsp_ready held low 5 cycles, then 300 erroring commands -> response payload stable while stalled and no new command accepted; err_cnt saturates at 255.
- reset_i asserted during ACCESS -> the next cycle shows psel/penable 0, cmd_ready 1, rsp_valid 0, err_cnt 0, and no response is ever emitted for the aborted command.

Source files
------------

// File: rtl/zigbee_apb_pkg.sv
// Shared types and constants for the Zigbee APB master.
package zigbee_apb_pkg;

    localparam int APB_DW = 8;

    localparam logic TGT_FIFO_TX = 1'b0;
    localparam logic TGT_FIFO_RX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

endpackage

// File: rtl/zigbee_apb_master.sv
// APB initiator turning one host command into one transfer on the Tx/Rx FIFO bus,
// with a PREADY timeout and a saturating error counter.
module zigbee_apb_master
    import zigbee_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_target_i,
    input  logic              cmd_write_i,
    input  logic [APB_DW-1:0] cmd_wdata_i,
    output logic              psel_tx_o,
    output logic              psel_rx_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [APB_DW-1:0] pwdata_o,
    input  logic [APB_DW-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [APB_DW-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic [7:0]        err_cnt_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    apb_state_t        state_q, state_d;
    logic              target_q, target_d;
    logic              write_q, write_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              bus_active;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        tmo_cnt_d = tmo_cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    target_d = cmd_target_i;
                    write_d  = cmd_write_i;
                    wdata_d  = cmd_wdata_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                tmo_cnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A pready arriving in the final allowed cycle still completes normally.
                if (pready_i) begin
                    rdata_d   = write_q ? '0 : prdata_i;
                    err_d     = pslverr_i;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    if (err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            target_q  <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            tmo_cnt_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            tmo_cnt_q <= tmo_cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs decode only from flops, so no input reaches an output combinationally.
    assign bus_active    = (state_q == SETUP) || (state_q == ACCESS);
    assign cmd_ready_o   = (state_q == IDLE);
    assign psel_tx_o     = bus_active && (target_q == TGT_FIFO_TX);
    assign psel_rx_o     = bus_active && (target_q == TGT_FIFO_RX);
    assign penable_o     = (state_q == ACCESS);
    assign pwrite_o      = bus_active && write_q;
    assign pwdata_o      = (bus_active && write_q) ? wdata_q : '0;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
